// File: rtl/btn_event_if.sv
// ---------------------------------------------------------------------------
// btn_event_if
//
// Purpose:
//    Bundles the button level coming from the debouncer together with the
//    event strobes and press counter that btn_event hands to the CPU input
//    port. Clock and reset are kept outside the interface as plain ports.
//
// Signals:
//    btn_n          debounced button level, active-low (0 = pressed)
//    press_pulse    one-cycle strobe on press
//    release_pulse  one-cycle strobe on release
//    long_pulse     one-cycle strobe when the hold reaches the long threshold
//    repeat_pulse   one-cycle auto-repeat strobe
//    held           level, high while the button is considered pressed
//    press_cnt      number of presses since reset, mod 256
//
// Modports:
//    master  the side that supplies the button level and consumes events
//    slave   btn_event itself
// ---------------------------------------------------------------------------
interface btn_event_if;

   logic       btn_n;
   logic       press_pulse;
   logic       release_pulse;
   logic       long_pulse;
   logic       repeat_pulse;
   logic       held;
   logic [7:0] press_cnt;

   // Upstream debouncer / CPU view: drives the level, observes the events.
   modport master (
      output btn_n,
      input  press_pulse,
      input  release_pulse,
      input  long_pulse,
      input  repeat_pulse,
      input  held,
      input  press_cnt
   );

   // Event generator view: observes the level, drives the events.
   modport slave (
      input  btn_n,
      output press_pulse,
      output release_pulse,
      output long_pulse,
      output repeat_pulse,
      output held,
      output press_cnt
   );

endinterface

// File: rtl/btn_event.sv
// ---------------------------------------------------------------------------
// btn_event
//
// Purpose:
//    Turns the debounced, active-low button level into registered one-cycle
//    event strobes: press, release, long-press and (optionally) auto-repeat,
//    plus a wrapping 8-bit press counter. The input is already synchronous
//    to clk, so no synchronizer is used here.
//
// Configuration macro:
//    BTN_REPEAT_EN  when defined, auto-repeat strobes are generated every
//                   REPEAT_CYCLES while the button stays in the long-press
//                   state. When undefined, the repeat logic is not built,
//                   repeat_pulse is tied to 0 and REPEAT_CYCLES is unused.
//
// Parameters:
//    LONG_CYCLES    hold time in clk cycles before long_pulse (>= 2)
//    REPEAT_CYCLES  auto-repeat period after long-press (>= 2)
//    CNT_W          hold counter width, must hold max(LONG, REPEAT) - 1
//
// Ports:
//    clk   system clock
//    rst   asynchronous, active-high reset
//    bus   btn_event_if.slave: btn_n in; press_pulse, release_pulse,
//          long_pulse, repeat_pulse, held, press_cnt out
// ---------------------------------------------------------------------------
module btn_event #(
   parameter int LONG_CYCLES   = 50_000_000,
   parameter int REPEAT_CYCLES = 10_000_000,
   parameter int CNT_W         = 26
) (
   input  logic           clk,
   input  logic           rst,
   btn_event_if.slave     bus
);

   // Reject parameter sets the hold counter cannot represent, or thresholds
   // so small that the press and the long-press would land on the same edge.
   if (LONG_CYCLES < 2 || REPEAT_CYCLES < 2 ||
       (LONG_CYCLES - 1) > ((2 ** CNT_W) - 1) ||
       (REPEAT_CYCLES - 1) > ((2 ** CNT_W) - 1)) begin : g_bad_params
      $error("btn_event: illegal LONG_CYCLES/REPEAT_CYCLES/CNT_W combination");
   end

   // Terminal counts of the hold counter. The counter is cleared on the
   // press edge, so reaching N-1 means N edges have elapsed since then.
   localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
`ifdef BTN_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
`endif

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PRESS = 2'd1,
      LONG  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             btn_d;
   logic [CNT_W-1:0] hold_cnt;
   logic [CNT_W-1:0] hold_cnt_nxt;
   logic [7:0]       press_cnt_q;
   logic [7:0]       press_cnt_nxt;
   logic             press_q;
   logic             press_nxt;
   logic             release_q;
   logic             release_nxt;
   logic             long_q;
   logic             long_nxt;
   logic             held_q;
`ifdef BTN_REPEAT_EN
   logic             repeat_q;
   logic             repeat_nxt;
`endif

   // Next-state and event logic. Every event is decided here and only
   // becomes visible after the register stage below, so each strobe is a
   // clean one-cycle registered pulse. A release sample is checked before
   // any hold threshold, so a release on the threshold edge suppresses the
   // long or repeat strobe, and at most one event fires per cycle.
   always_comb begin
      state_nxt     = state;
      hold_cnt_nxt  = hold_cnt;
      press_cnt_nxt = press_cnt_q;
      press_nxt     = 1'b0;
      release_nxt   = 1'b0;
      long_nxt      = 1'b0;
`ifdef BTN_REPEAT_EN
      repeat_nxt    = 1'b0;
`endif

      case (state)
         IDLE: begin
            if (btn_d && !bus.btn_n) begin
               press_nxt     = 1'b1;
               hold_cnt_nxt  = '0;
               press_cnt_nxt = press_cnt_q + 8'd1;
               state_nxt     = PRESS;
            end
         end

         PRESS: begin
            if (bus.btn_n) begin
               release_nxt  = 1'b1;
               hold_cnt_nxt = '0;
               state_nxt    = IDLE;
            end else if (hold_cnt == LONG_LAST) begin
               long_nxt     = 1'b1;
               hold_cnt_nxt = '0;
               state_nxt    = LONG;
            end else begin
               hold_cnt_nxt = hold_cnt + CNT_W'(1);
            end
         end

         LONG: begin
            if (bus.btn_n) begin
               release_nxt  = 1'b1;
               hold_cnt_nxt = '0;
               state_nxt    = IDLE;
            end else begin
`ifdef BTN_REPEAT_EN
               if (hold_cnt == REPEAT_LAST) begin
                  repeat_nxt   = 1'b1;
                  hold_cnt_nxt = '0;
               end else begin
                  hold_cnt_nxt = hold_cnt + CNT_W'(1);
               end
`else
               hold_cnt_nxt = '0;
`endif
            end
         end

         default: begin
            hold_cnt_nxt = '0;
            state_nxt    = IDLE;
         end
      endcase
   end

   // State, counters and output registers. btn_d resets to 1 (released) so
   // a button already held when reset is released counts as a fresh press
   // on the very first edge. held follows the state being entered, so it
   // rises and falls on the same edges as press_pulse and release_pulse.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         btn_d       <= 1'b1;
         hold_cnt    <= '0;
         press_cnt_q <= 8'd0;
         press_q     <= 1'b0;
         release_q   <= 1'b0;
         long_q      <= 1'b0;
         held_q      <= 1'b0;
      end else begin
         state       <= state_nxt;
         btn_d       <= bus.btn_n;
         hold_cnt    <= hold_cnt_nxt;
         press_cnt_q <= press_cnt_nxt;
         press_q     <= press_nxt;
         release_q   <= release_nxt;
         long_q      <= long_nxt;
         held_q      <= (state_nxt != IDLE);
      end
   end

`ifdef BTN_REPEAT_EN
   // Auto-repeat strobe register, only present when repeat is enabled.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         repeat_q <= 1'b0;
      end else begin
         repeat_q <= repeat_nxt;
      end
   end

   assign bus.repeat_pulse = repeat_q;
`else
   assign bus.repeat_pulse = 1'b0;
`endif

   assign bus.press_pulse   = press_q;
   assign bus.release_pulse = release_q;
   assign bus.long_pulse    = long_q;
   assign bus.held          = held_q;
   assign bus.press_cnt     = press_cnt_q;

endmodule

// File: tb/tb_btn_event.sv
// ---------------------------------------------------------------------------
// tb_btn_event
//
// Purpose:
//    Self-checking bench for btn_event with LONG_CYCLES=8, REPEAT_CYCLES=4,
//    CNT_W=4. A reference model tracks the press start edge and derives the
//    expected strobes from the elapsed edge count with plain arithmetic.
//    Honours BTN_REPEAT_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_btn_event;

   localparam int L = 8;
   localparam int R = 4;
`ifdef BTN_REPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   btn_event_if bus ();

   btn_event #(
      .LONG_CYCLES   (L),
      .REPEAT_CYCLES (R),
      .CNT_W         (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // 100 MHz-ish free-running bench clock.
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // Reference model state: whether the button counts as pressed, the
   // previous sample, the edge index of the press and the running count.
   bit         m_pressed;
   bit         m_prev;
   int         m_start;
   int         m_edge = 0;
   logic [7:0] m_cnt;
   bit         e_press;
   bit         e_rel;
   bit         e_long;
   bit         e_rep;

   task automatic modelReset();
      m_pressed = 1'b0;
      m_prev    = 1'b1;
      m_cnt     = 8'd0;
      e_press   = 1'b0;
      e_rel     = 1'b0;
      e_long    = 1'b0;
      e_rep     = 1'b0;
   endtask

   // Expected events for one clock edge that samples button level b.
   task automatic modelStep(input bit b);
      int d;
      e_press = 1'b0;
      e_rel   = 1'b0;
      e_long  = 1'b0;
      e_rep   = 1'b0;
      if (!m_pressed) begin
         if (!b && m_prev) begin
            e_press   = 1'b1;
            m_pressed = 1'b1;
            m_start   = m_edge;
            m_cnt     = m_cnt + 8'd1;
         end
      end else if (b) begin
         e_rel     = 1'b1;
         m_pressed = 1'b0;
      end else begin
         d = m_edge - m_start;
         if (d == L)
            e_long = 1'b1;
         else if (REP_EN && d > L && ((d - L) % R) == 0)
            e_rep = 1'b1;
      end
      m_prev = b;
      m_edge = m_edge + 1;
   endtask

   task automatic checkVal(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic checkOutput();
      checkVal("press_pulse",   {7'd0, bus.press_pulse},   {7'd0, e_press});
      checkVal("release_pulse", {7'd0, bus.release_pulse}, {7'd0, e_rel});
      checkVal("long_pulse",    {7'd0, bus.long_pulse},    {7'd0, e_long});
      checkVal("repeat_pulse",  {7'd0, bus.repeat_pulse},  {7'd0, e_rep});
      checkVal("held",          {7'd0, bus.held},          {7'd0, m_pressed});
      checkVal("press_cnt",     bus.press_cnt,             m_cnt);
   endtask

   // Drive one level for one clock edge, advance the model, check #1 later.
   task automatic applyStimulus(input bit b);
      bus.btn_n = b;
      @(posedge clk);
      if (rst)
         modelReset();
      else
         modelStep(b);
      #1;
      checkOutput();
   endtask

   task automatic pressFor(input int low, input int high);
      repeat (low) applyStimulus(1'b0);
      repeat (high) applyStimulus(1'b1);
   endtask

   initial begin
      rst       = 1'b1;
      bus.btn_n = 1'b1;
      modelReset();

      // Reset state with the button released.
      repeat (2) applyStimulus(1'b1);
      #2 rst = 1'b0;
      repeat (2) applyStimulus(1'b1);

      // Short press of three cycles.
      pressFor(3, 3);
      checkVal("short_cnt", bus.press_cnt, 8'd1);

      // Long hold of twenty cycles: long strobe, then repeats if enabled.
      pressFor(20, 3);

      // Release exactly on the long threshold edge, and its neighbours.
      pressFor(8, 3);
      pressFor(7, 2);
      pressFor(9, 2);
      pressFor(12, 2);

      // Randomized presses of varied length.
      repeat (60) pressFor($urandom_range(1, 30), $urandom_range(1, 4));

      // Counter wrap: 256 presses from a known zero.
      #2 rst = 1'b1;
      bus.btn_n = 1'b1;
      #1 modelReset();
      checkOutput();
      applyStimulus(1'b1);
      #2 rst = 1'b0;
      repeat (256) pressFor(1, 1);
      checkVal("wrap_zero", bus.press_cnt, 8'd0);
      pressFor(1, 1);
      checkVal("wrap_one", bus.press_cnt, 8'd1);

      // Reset in the middle of a hold, button still held across reset.
      applyStimulus(1'b1);
      repeat (5) applyStimulus(1'b0);
      #2 rst = 1'b1;
      #1 modelReset();
      checkOutput();
      applyStimulus(1'b0);
      #2 rst = 1'b0;
      applyStimulus(1'b0);
      checkVal("rst_press", {7'd0, bus.press_pulse}, 8'd1);
      checkVal("rst_cnt", bus.press_cnt, 8'd1);
      pressFor(10, 2);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
